fpga_mem_dump_reader: RTL and testbench

- FPGA-side reader for the processor's data-memory debug port.
- Waits for the core to report program completion, then takes over the data-cache address path (address_mode, fpga_address).
- Walks a configured word range, waits out the synchronous memory read latency, and streams each fpga_value word out on a valid/ready interface.
- Sits beside the processor top level in the board wrapper; the stream feeds the display or serial output logic.

---
 rtl/fpga_mem_dump_reader.sv | 129 ++++++++++++
 tb/tb_fpga_mem_dump_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fpga_mem_dump_reader.sv
// fpga_mem_dump_reader: after program completion, takes over the data-memory address
// path, reads a word range and streams each word out on a valid/ready interface.
module fpga_mem_dump_reader #(
    parameter logic [31:0] ADDR_START   = 32'h0,
    parameter int unsigned WORD_COUNT   = 16,
    parameter logic [31:0] ADDR_STEP    = 32'h1,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          AUTO_START   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        program_done,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] fpga_value,
    output logic        address_mode,
    output logic [31:0] fpga_address,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, FINISH} state_t;

    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [15:0] IDX_LAST = 16'(WORD_COUNT - 1);

    state_t      state, state_nxt;
    logic        pd_q, trigger, kill;
    logic [15:0] idx, idx_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        am_nxt, valid_nxt, last_nxt, busy_nxt, done_nxt;
    logic [31:0] addr_nxt, data_nxt;

    assign trigger = program_done & (start | (AUTO_START & ~pd_q));
    assign kill    = abort & (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pd_q         <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            address_mode <= 1'b0;
            fpga_address <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            pd_q         <= program_done;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            address_mode <= am_nxt;
            fpga_address <= addr_nxt;
            out_data     <= data_nxt;
            out_valid    <= valid_nxt;
            out_last     <= last_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = trigger ? ISSUE : IDLE;
            ISSUE:   state_nxt = (cnt == LAT_LAST) ? CAPTURE : ISSUE;
            CAPTURE: state_nxt = PRESENT;
            PRESENT: state_nxt = out_ready ? (out_last ? FINISH : ISSUE) : PRESENT;
            default: state_nxt = IDLE;
        endcase
        if (kill)
            state_nxt = IDLE;
    end

    always_comb begin
        am_nxt    = address_mode;
        addr_nxt  = fpga_address;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        busy_nxt  = busy;
        done_nxt  = done;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        if (kill) begin
            am_nxt    = 1'b0;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: if (trigger) begin
                    am_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                    done_nxt = 1'b0;
                    addr_nxt = ADDR_START;
                    idx_nxt  = '0;
                    cnt_nxt  = '0;
                end
                ISSUE: cnt_nxt = cnt + 2'd1;
                CAPTURE: begin
                    data_nxt  = fpga_value;
                    valid_nxt = 1'b1;
                    last_nxt  = (idx == IDX_LAST);
                end
                PRESENT: if (out_ready) begin
                    valid_nxt = 1'b0;
                    if (!out_last) begin
                        idx_nxt  = idx + 16'd1;
                        addr_nxt = fpga_address + ADDR_STEP;
                        cnt_nxt  = '0;
                    end
                end
                default: begin
                    am_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    last_nxt = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpga_mem_dump_reader.sv
// tb_fpga_mem_dump_reader: directed checks of two reader configurations
// (latency 1 / 4 words, and latency 3 / wrapping addresses / auto start).
module tb_fpga_mem_dump_reader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    logic        pd_a = 1'b0, start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
    logic [31:0] val_a;
    logic        am_a, valid_a, last_a, busy_a, done_a;
    logic [31:0] addr_a, data_a;
    logic [31:0] mem_a [0:3] = '{32'h11, 32'h22, 32'h33, 32'h44};

    logic        pd_b = 1'b0, start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
    logic [31:0] val_b, p1_b, p2_b;
    logic        am_b, valid_b, last_b, busy_b, done_b;
    logic [31:0] addr_b, data_b;

    fpga_mem_dump_reader #(.WORD_COUNT(4), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .program_done(pd_a), .start(start_a), .abort(abort_a),
        .fpga_value(val_a), .address_mode(am_a), .fpga_address(addr_a), .out_data(data_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    fpga_mem_dump_reader #(.ADDR_START(32'hFFFF_FFFE), .WORD_COUNT(3), .READ_LATENCY(3),
                           .AUTO_START(1'b1)) dut_b (
        .clk(clk), .reset(reset), .program_done(pd_b), .start(start_b), .abort(abort_b),
        .fpga_value(val_b), .address_mode(am_b), .fpga_address(addr_b), .out_data(data_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    // memory models: one-stage read for A, three-stage read for B
    always @(posedge clk) val_a <= mem_a[addr_a[1:0]];
    always @(posedge clk) begin
        p1_b  <= {addr_b[15:0], 16'hBEEF};
        p2_b  <= p1_b;
        val_b <= p2_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dump_a(input int stall_k);
        pd_a = 1'b1;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("trig_busy", busy_a, 1);
        chk("trig_am", am_a, 1);
        chk("trig_done", done_a, 0);
        chk("trig_addr", addr_a, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("gap_valid", valid_a, 0);
            tick;
            chk("word_valid", valid_a, 1);
            chk("word_data", data_a, mem_a[k]);
            chk("word_last", last_a, 32'(k == 3));
            chk("word_addr", addr_a, 32'(k));
            if (k == stall_k) begin
                ready_a = 1'b0;
                repeat (5) begin
                    tick;
                    chk("stall_valid", valid_a, 1);
                    chk("stall_data", data_a, mem_a[k]);
                    chk("stall_addr", addr_a, 32'(k));
                end
                ready_a = 1'b1;
            end
            tick;
        end
        chk("fin_valid", valid_a, 0);
        chk("fin_busy", busy_a, 1);
        tick;
        chk("end_done", done_a, 1);
        chk("end_am", am_a, 0);
        chk("end_busy", busy_a, 0);
        chk("end_last", last_a, 0);
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_am", am_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        reset = 1'b1;
        tick;
        // start without program_done is ignored
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        tick;
        chk("nopd_busy", busy_a, 0);
        chk("nopd_am", am_a, 0);
        chk("nopd_done", done_a, 0);

        dump_a(-1);
        dump_a(2);

        // abort on the cycle word 1 is accepted
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (5) tick;
        chk("ab_valid_pre", valid_a, 1);
        chk("ab_data_pre", data_a, 32'h22);
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
        chk("ab_busy", busy_a, 0);
        chk("ab_valid", valid_a, 0);
        chk("ab_am", am_a, 0);
        chk("ab_done", done_a, 0);
        chk("ab_last", last_a, 0);
        repeat (3) tick;
        chk("ab_idle_busy", busy_a, 0);
        dump_a(-1);

        // auto start, wrapping addresses, latency 3; program_done drops mid-dump
        pd_b = 1'b1;
        tick;
        chk("b_busy", busy_b, 1);
        chk("b_am", am_b, 1);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) pd_b = 1'b0;
            chk("b_addr", addr_b, 32'hFFFF_FFFE + 32'(k));
            repeat (3) begin
                tick;
                chk("b_wait_valid", valid_b, 0);
            end
            tick;
            chk("b_valid", valid_b, 1);
            chk("b_data", data_b, {16'hFFFE + 16'(k), 16'hBEEF});
            chk("b_last", last_b, 32'(k == 2));
            tick;
        end
        tick;
        chk("b_done", done_b, 1);
        chk("b_end_am", am_b, 0);

        // asynchronous reset in the middle of ISSUE
        tick;
        pd_b = 1'b1;
        tick;
        chk("b2_busy", busy_b, 1);
        chk("b2_done", done_b, 0);
        tick;
        #2 reset = 1'b0;
        #1;
        chk("arst_am", am_b, 0);
        chk("arst_busy", busy_b, 0);
        chk("arst_addr", addr_b, 0);
        chk("arst_done", done_b, 0);
        tick;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
